uart_rx: RTL and testbench

- 8N1 UART receiver: the receive side of the board's serial link, paired with the existing transmitter.
- Synchronises the asynchronous rx pin into the clk domain and detects start bits.
- Samples each bit at mid-bit and delivers one byte per frame as a single-cycle valid pulse.
- Reports framing errors and holds off on line-break (rx held low) until the line returns idle-high.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid /
// framing-error pulses, and break hold-off until the line returns idle-high.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_TERM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_rate_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_s1_q, rx_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_sync_q <= rx_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            // Lags the state by one cycle so busy still covers the valid pulse.
            busy_q    <= (state_q != S_IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_TERM) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_TERM) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_TERM) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Only a return to idle-high re-arms start detection.
                cnt_d = '0;
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, multi-cycle corner sequences,
// randomized frames against a frame-level reference model, and a real-rate frame.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int C      = CLK_HZ / BAUD;
    localparam int H      = C / 2;
    localparam int LAT    = 2 + H + 9 * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;

    logic       clk_f = 1'b0;
    logic       rx_f = 1'b1;
    logic [7:0] rx_data_f;
    logic       rx_valid_f, frame_err_f, busy_f;

    always #5  clk   = ~clk;
    always #10 clk_f = ~clk_f;

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.CLK_FREQ_HZ(50_000_000), .BAUD_RATE(115_200)) dut_fast (
        .clk(clk_f), .rst_n(rst_n), .rx(rx_f), .rx_data(rx_data_f),
        .rx_valid(rx_valid_f), .frame_err(frame_err_f), .busy(busy_f)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         err;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  cyc = 0;
    bit  busy_log [0:65535];
    int  both_high = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cyc < 65536) busy_log[cyc] = busy;
        if (rx_valid)  obs_q.push_back('{cyc, rx_data, 1'b0});
        if (frame_err) obs_q.push_back('{cyc, rx_data, 1'b1});
        if (rx_valid && frame_err) both_high++;
    end

    int         fvalid_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] fdata = 8'h00;

    always @(negedge clk_f) begin
        if (rx_valid_f) begin
            fvalid_cnt++;
            fdata = rx_data_f;
        end
        if (frame_err_f) ferr_cnt++;
    end

    // Drives one frame from a negedge; returns the cycle at which rx_s1 sees the start bit.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int hold_low_bits,
                              input int gap_bits, output int t0);
        t0 = cyc + 1;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C) @(negedge clk);
        rx = 1'b0;
        repeat (hold_low_bits * C) @(negedge clk);
        rx = 1'b1;
        repeat (gap_bits * C) @(negedge clk);
    endtask

    // Frame-level model: the outcome of a frame depends only on its stop bit.
    logic [7:0] last_good = 8'h00;

    task automatic model_frame(input int t0, input logic [7:0] b, input bit stop);
        if (stop) begin
            exp_q.push_back('{t0 + LAT, b, 1'b0});
            last_good = b;
        end else begin
            exp_q.push_back('{t0 + LAT, last_good, 1'b1});
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk($sformatf("%s_event_count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]_cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s[%0d]_data", tag, i), int'(obs_q[i].data), int'(exp_q[i].data));
            chk($sformatf("%s[%0d]_is_err", tag, i), int'(obs_q[i].err), int'(exp_q[i].err));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         hold_low;
        int         gap;
        bit         exp_valid;
        bit         exp_err;
        logic [7:0] exp_rxdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int         t0;
        int         nbad;
        string      msg;
        logic [7:0] b;
        bit         stop;
        int         gap, hold;
        logic [7:0] fb;

        vecs[0] = '{8'h48, 1'b1, 0,  1, 1'b1, 1'b0, 8'h48};
        vecs[1] = '{8'h55, 1'b0, 50, 2, 1'b0, 1'b1, 8'h48};
        vecs[2] = '{8'hA5, 1'b1, 0,  1, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{8'h00, 1'b1, 0,  1, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0,  1, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h81, 1'b0, 0,  1, 1'b0, 1'b1, 8'hFF};
        vecs[6] = '{8'h7E, 1'b1, 0,  0, 1'b1, 1'b0, 8'h7E};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_rx_data",   int'(rx_data),   0);
        chk("reset_rx_valid",  int'(rx_valid),  0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_busy",      int'(busy),      0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * C) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].hold_low, vecs[v].gap, t0);
            chk($sformatf("vec%0d_event_count", v), obs_q.size(), 1);
            if (obs_q.size() >= 1) begin
                chk($sformatf("vec%0d_cycle", v), obs_q[0].cyc, t0 + LAT);
                chk($sformatf("vec%0d_valid", v), int'(!obs_q[0].err), int'(vecs[v].exp_valid));
                chk($sformatf("vec%0d_frame_err", v), int'(obs_q[0].err), int'(vecs[v].exp_err));
                chk($sformatf("vec%0d_rx_data", v), int'(obs_q[0].data), int'(vecs[v].exp_rxdata));
            end
            if (v == 0) begin
                nbad = 0;
                for (int c = t0 + 3; c <= t0 + LAT; c++) if (!busy_log[c]) nbad++;
                chk("busy_low_cycles_in_frame", nbad, 0);
                chk("busy_after_pulse", int'(busy_log[t0 + LAT + 1]), 0);
            end
            obs_q.delete();
        end
        last_good = 8'h7E;

        msg = "Hello World!\n";
        for (int i = 0; i < msg.len(); i++) begin
            send_frame(msg[i], 1'b1, 0, 0, t0);
            model_frame(t0, msg[i], 1'b1);
        end
        repeat (C) @(negedge clk);
        compare_events("hello");

        t0 = cyc + 1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (H + 3) @(negedge clk);
        chk("glitch_busy_released", int'(busy), 0);
        repeat (3 * C) @(negedge clk);
        chk("glitch_no_events", obs_q.size(), 0);
        obs_q.delete();

        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (C) @(negedge clk);
        end
        rx = 1'b1;
        repeat (H) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rx_data",   int'(rx_data),   0);
        chk("midreset_rx_valid",  int'(rx_valid),  0);
        chk("midreset_frame_err", int'(frame_err), 0);
        chk("midreset_busy",      int'(busy),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * C) @(negedge clk);
        chk("midreset_no_events", obs_q.size(), 0);
        obs_q.delete();
        last_good = 8'h00;
        send_frame(8'h3C, 1'b1, 0, 1, t0);
        model_frame(t0, 8'h3C, 1'b1);
        compare_events("after_reset");

        for (int i = 0; i < 25; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            hold = stop ? 0 : $urandom_range(0, 3);
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 3);
            send_frame(b, stop, hold, gap, t0);
            model_frame(t0, b, stop);
        end
        repeat (C) @(negedge clk);
        compare_events("random");
        chk("valid_err_overlap", both_high, 0);

        fb = 8'h0D;
        #1000;
        rx_f = 1'b0;
        #8680;
        for (int i = 0; i < 8; i++) begin
            rx_f = fb[i];
            #8680;
        end
        rx_f = 1'b1;
        #20000;
        chk("fast_valid_count", fvalid_cnt, 1);
        chk("fast_rx_data", int'(fdata), 8'h0D);
        chk("fast_frame_err", ferr_cnt, 0);
        chk("fast_busy_idle", int'(busy_f), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
